// File: rtl/grid_mem_ctrl_if.sv
// Bus bundle for the game-grid status memory:
// VGA read port, two write requesters, clear control.
interface grid_mem_ctrl_if;
  logic [7:0] vga_addr;
  logic [1:0] vga_status;
  logic       req0;
  logic [7:0] addr0;
  logic [1:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] addr1;
  logic [1:0] data1;
  logic       ack1;
  logic       clear_start;
  logic       busy;
  logic [7:0] hit_count;

  modport slave (
    input  vga_addr,
    input  req0,
    input  addr0,
    input  data0,
    input  req1,
    input  addr1,
    input  data1,
    input  clear_start,
    output vga_status,
    output ack0,
    output ack1,
    output busy,
    output hit_count
  );

  modport master (
    output vga_addr,
    output req0,
    output addr0,
    output data0,
    output req1,
    output addr1,
    output data1,
    output clear_start,
    input  vga_status,
    input  ack0,
    input  ack1,
    input  busy,
    input  hit_count
  );
endinterface

// File: rtl/grid_mem_ctrl.sv
// 256 x 2-bit grid status memory with a free-running VGA read,
// round-robin write arbitration, a clear sweep and a HIT counter.
module grid_mem_ctrl #(
  parameter int GRID_ROWS    = 12,
  parameter int GRID_COLUMNS = 12
) (
  input  logic           clk,
  input  logic           rst,
  grid_mem_ctrl_if.slave bus
);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  localparam logic [4:0] COLS    = 5'(GRID_COLUMNS);
  localparam logic [4:0] ROWS    = 5'(GRID_ROWS);
  localparam logic [7:0] HIT_MAX = 8'(GRID_ROWS * GRID_COLUMNS);

  logic [1:0] mem_q [256];

  state_e     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic       last_q, last_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       busy_q;
  logic [7:0] hit_q, hit_d;
  logic [1:0] vga_q, vga_d;

  logic       el0, el1;
  logic       gnt0, gnt1;
  logic       we;
  logic [7:0] wa;
  logic [1:0] wd;
  logic [1:0] old;

  function automatic logic in_grid(
    input logic [7:0] a
  );
    return ({1'b0, a[7:4]} < COLS) &&
           ({1'b0, a[3:0]} < ROWS);
  endfunction

  always_comb begin
    vga_d = 2'b00;
    if (in_grid(bus.vga_addr)) begin
      vga_d = mem_q[bus.vga_addr];
    end
  end

  // A requester just acked is held off for one
  // cycle so a still-high req is not rewritten.
  assign el0 = bus.req0 && !ack0_q;
  assign el1 = bus.req1 && !ack1_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    hit_d   = hit_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    we      = 1'b0;
    wa      = ptr_q;
    wd      = 2'b00;
    old     = 2'b00;
    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        ptr_d = ptr_q + 8'd1;
        hit_d = 8'd0;
        if (ptr_q == 8'hff) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (bus.clear_start) begin
          state_d = CLEAR;
          ptr_d   = 8'd0;
          hit_d   = 8'd0;
        end else begin
          unique case (1'b1)
            el0 && el1: begin
              gnt0 = last_q;
              gnt1 = !last_q;
            end
            el0 && !el1: gnt0 = 1'b1;
            !el0 && el1: gnt1 = 1'b1;
            default: ;
          endcase
          if (gnt0) begin
            wa     = bus.addr0;
            wd     = bus.data0;
            we     = in_grid(bus.addr0);
            last_d = 1'b0;
          end
          if (gnt1) begin
            wa     = bus.addr1;
            wd     = bus.data1;
            we     = in_grid(bus.addr1);
            last_d = 1'b1;
          end
          if (we) begin
            old = mem_q[wa];
            if (wd == 2'b11 && old != 2'b11 &&
                hit_q != HIT_MAX) begin
              hit_d = hit_q + 8'd1;
            end else if (wd != 2'b11 &&
                         old == 2'b11 &&
                         hit_q != 8'd0) begin
              hit_d = hit_q - 8'd1;
            end
          end
        end
      end
      default: ;
    endcase
    ack0_d = gnt0;
    ack1_d = gnt1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= 8'd0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b1;
      hit_q   <= 8'd0;
      vga_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= (state_d == CLEAR);
      hit_q   <= hit_d;
      vga_q   <= vga_d;
    end
  end

  // Contents are not reset; the sweep after reset zeroes them.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem_q[wa] <= wd;
    end
  end

  assign bus.vga_status = vga_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.busy       = busy_q;
  assign bus.hit_count  = hit_q;

endmodule

// File: doc/grid_mem_ctrl.md
GRID_MEM_CTRL -- requirements
Module: grid_mem_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- GRID_ROWS, 12, valid y indices 0..GRID_ROWS-1
- GRID_COLUMNS, 12, valid x indices 0..GRID_COLUMNS-1

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, reset; synchronous, active-high
- vga_addr, in, 8, VGA-side read address {x[3:0], y[3:0]}
- vga_status, out, 2, grid status at vga_addr
- req0 / req1, in, 1, write request, requester 0 (local placement) / requester 1 (remote shot result)
- addr0 / addr1, in, 8, write address {x[3:0], y[3:0]}
- data0 / data1, in, 2, status to write: 00 EMPTY, 01 MYSHIP, 10 MISS, 11 HIT
- ack0 / ack1, out, 1, one-cycle write-complete pulse
- clear_start, in, 1, pulse that starts a full grid clear
- busy, out, 1, high while a clear sweep runs
- hit_count, out, 8, number of cells currently holding HIT

Function
REQ-003 The block SHALL store 256 entries of 2 bits each; an address is in-grid iff x<GRID_COLUMNS and y<GRID_ROWS.
REQ-004 vga_status SHALL be registered, with 1-cycle latency: vga_status(t+1) = mem[vga_addr(t)].
REQ-005 vga_status SHALL be 00 for out-of-grid vga_addr.
REQ-006 The VGA read SHALL never stall, and SHALL be unaffected by arbitration or clear, except for the data actually written.
REQ-007 A VGA read and a write to the same address in the same cycle SHALL return the old value (read-before-write).
REQ-008 The FSM SHALL have states CLEAR and IDLE. The reset state SHALL be CLEAR with clear pointer 0.
REQ-009 In CLEAR, the block SHALL write 00 to mem[ptr] and increment ptr each cycle. After ptr=255 it SHALL enter IDLE; a sweep therefore lasts exactly 256 cycles.
REQ-010 busy SHALL be 1 exactly while in CLEAR.
REQ-011 In IDLE, clear_start=1 SHALL transition to CLEAR with ptr=0 on the next edge, and SHALL take priority over a pending grant that cycle (no write, no ack).
REQ-012 clear_start SHALL be ignored while already in CLEAR; the sweep is not restarted.
REQ-013 In IDLE, the block SHALL grant at most one requester per cycle.
REQ-014 With only one requester asserting req, that requester SHALL be granted.
REQ-015 With both asserting req, the block SHALL grant the requester not granted most recently (round-robin). The last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-016 For a grant in cycle t, the block SHALL commit the write at edge t+1 and assert ackN=1 for cycle t+1 only.
REQ-017 The requester SHALL hold req, addr and data stable until it sees ack. The granted requester SHALL be ineligible in cycle t+1, so no double write occurs if req stays high during the ack cycle.
REQ-018 Out-of-grid write addresses SHALL be acked normally, with memory and hit_count unchanged.
REQ-019 No ack SHALL be issued in CLEAR; requests SHALL remain pending and be served after the return to IDLE.
REQ-020 hit_count SHALL increment by 1 on a committed write of 11 to a cell whose old value is not 11.
REQ-021 hit_count SHALL decrement by 1 on a committed write of a non-11 value to a cell whose old value is 11.
REQ-022 hit_count SHALL be unchanged otherwise, including on rewriting HIT over HIT.
REQ-023 hit_count SHALL become 0 on entry to CLEAR, and SHALL saturate at 144 and never wrap.
REQ-024 ack0, ack1 and busy SHALL be registered outputs.

Reset
REQ-025 While rst=1, the block SHALL drive vga_status=0, ack0=ack1=0, hit_count=0, ptr=0, last-grant=1, and state=CLEAR; busy SHALL be 1 from the first edge after rst asserts.
REQ-026 After rst deasserts, the sweep SHALL run 256 cycles, then busy SHALL fall.
REQ-027 rst asserted mid-write or mid-clear SHALL abort the operation, issue no ack, and restart the full sweep.

Verification
REQ-028 Reset release -> busy=1 for exactly 256 cycles; every vga_addr then reads 00; hit_count=0.
REQ-029 req0 with addr0=8'h35, data0=2'b01 -> ack0 pulses for exactly 1 cycle; vga_addr=8'h35 reads 01 one cycle after it is applied.
REQ-030 req0 and req1 held simultaneously for 4 writes -> acks in order 0,1,0,1, with no ack in consecutive cycles to the same requester and no duplicate writes.
REQ-031 Write 11 to 8'h00, 8'h00 again, 8'h01, then 10 to 8'h01 -> hit_count sequence 1,1,2,1.
REQ-032 Write to 8'hC0 (x=12) -> ack asserted, hit_count unchanged, vga_status 00 there.
REQ-033 clear_start in the same cycle req1 is granted -> no ack1, busy=1; ack1 is issued after the 256-cycle sweep; hit_count=0 during the sweep.
